// File: rtl/bus_mem.sv
// Word-addressed memory responder for the cpu load/store/fetch bus, with a
// pipelined read path and a small MMIO window (cycle counter, debug register).
module bus_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LATENCY  = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] o_addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [7:0]  debug_out,
    output logic        bus_err
);

    localparam int unsigned AW            = $clog2(DEPTH_WORDS);
    localparam logic [13:0] IDX_CYCLES    = 14'h3FFE;
    localparam logic [13:0] IDX_DEBUG     = 14'h3FFF;
    localparam logic [31:0] UNMAPPED_WORD = 32'hDEADBEEF;

    // Request protocol: rd_en / wr_en are one-cycle pulses with no ready or
    // acknowledge; every pulse is taken on the edge that samples it.

    logic [31:0] mem [DEPTH_WORDS];

    logic [13:0] word_idx;
    logic        unused_byte_lanes;
    logic        is_zero;
    logic        is_cycles;
    logic        is_debug;
    logic        is_ram;
    logic        is_unmapped;
    logic        rd_accept;
    logic [31:0] rd_word;

    assign word_idx          = o_addr[15:2];
    assign unused_byte_lanes = ^o_addr[1:0];

    always_comb begin
        is_zero     = (word_idx == 14'd0);
        is_cycles   = (word_idx == IDX_CYCLES);
        is_debug    = (word_idx == IDX_DEBUG);
        is_ram      = !is_zero && !is_cycles && !is_debug &&
                      (32'(word_idx) < DEPTH_WORDS);
        is_unmapped = !(is_zero || is_cycles || is_debug || is_ram);
        rd_accept   = rd_en && !wr_en;
    end

    logic [31:0] cycles_q;
    logic [7:0]  debug_q;
    logic [7:0]  debug_d;
    logic        bus_err_q;
    logic        bus_err_d;

    // Snapshot taken from pre-edge state, so a write on the same edge is not seen.
    always_comb begin
        rd_word = 32'd0;
        if (is_cycles) begin
            rd_word = cycles_q;
        end else if (is_debug) begin
            rd_word = {24'd0, debug_q};
        end else if (is_ram) begin
            rd_word = mem[word_idx[AW-1:0]];
        end else if (is_unmapped) begin
            rd_word = UNMAPPED_WORD;
        end
    end

    always_comb begin
        debug_d   = debug_q;
        bus_err_d = bus_err_q;
        if (wr_en && is_debug) begin
            debug_d = wr_data[7:0];
        end
        if (((rd_en || wr_en) && is_unmapped) || (rd_en && wr_en)) begin
            bus_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && is_ram) begin
            mem[word_idx[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q  <= 32'd0;
            debug_q   <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            cycles_q  <= cycles_q + 32'd1;
            debug_q   <= debug_d;
            bus_err_q <= bus_err_d;
        end
    end

    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [31:0]           pipe_dat_q  [RD_LATENCY];
    logic [RD_LATENCY-1:0] pipe_vld_in;
    logic [31:0]           pipe_dat_in [RD_LATENCY];

    always_comb begin
        pipe_vld_in[0] = rd_accept;
        pipe_dat_in[0] = rd_word;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_in[i] = pipe_vld_q[i-1];
            pipe_dat_in[i] = pipe_dat_q[i-1];
        end
    end

    // Data stages only load behind a valid, which makes the last stage hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_dat_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_in[i];
                if (pipe_vld_in[i]) begin
                    pipe_dat_q[i] <= pipe_dat_in[i];
                end
            end
        end
    end

    assign rd_valid  = pipe_vld_q[RD_LATENCY-1];
    assign rd_data   = pipe_dat_q[RD_LATENCY-1];
    assign debug_out = debug_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_bus_mem.sv
// Bench for bus_mem: one instance at read latency 1 and one at latency 3 share
// the same request stream; a rule-level model predicts every output cycle.
module tb_bus_mem;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic [15:0] o_addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data1, rd_data3;
  logic        rd_valid1, rd_valid3;
  logic [7:0]  dbg1, dbg3;
  logic        err1, err3;

  bus_mem #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(1), .INIT_FILE("")) dut1 (
    .clk(clk), .rst_n(rst_n), .o_addr(o_addr), .rd_en(rd_en), .wr_en(wr_en),
    .wr_data(wr_data), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .debug_out(dbg1), .bus_err(err1)
  );

  bus_mem #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(3), .INIT_FILE("")) dut3 (
    .clk(clk), .rst_n(rst_n), .o_addr(o_addr), .rd_en(rd_en), .wr_en(wr_en),
    .wr_data(wr_data), .rd_data(rd_data3), .rd_valid(rd_valid3),
    .debug_out(dbg3), .bus_err(err3)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_cyc;
  logic [7:0]  m_dbg;
  logic        m_err;
  int          ecount;
  logic [31:0] held1, held3;
  int          due1_q[$], due3_q[$];
  logic [31:0] exp1_q[$], exp3_q[$];

  function automatic void model_reset();
    m_cyc = 0; m_dbg = 0; m_err = 0;
    held1 = 0; held3 = 0;
    due1_q.delete(); due3_q.delete(); exp1_q.delete(); exp3_q.delete();
  endfunction

  function automatic void model_edge(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d);
    int idx;
    logic [31:0] val;
    logic special, ram;
    idx = int'(a) / 4;
    special = (idx == 0) || (idx == 16'h3FFE) || (idx == 16'h3FFF);
    ram = !special && (idx < DEPTH);
    if (idx == 0) val = 0;
    else if (idx == 16'h3FFE) val = m_cyc;
    else if (idx == 16'h3FFF) val = {24'd0, m_dbg};
    else if (ram) val = m_mem[idx];
    else val = 32'hDEADBEEF;
    ecount++;
    if (rd && !wr) begin
      due1_q.push_back(ecount);     exp1_q.push_back(val);
      due3_q.push_back(ecount + 2); exp3_q.push_back(val);
    end
    if (wr) begin
      if (idx == 16'h3FFF) m_dbg = d[7:0];
      else if (ram) m_mem[idx] = d;
    end
    if ((rd || wr) && !special && !ram) m_err = 1;
    if (rd && wr) m_err = 1;
    m_cyc = m_cyc + 1;
  endfunction

  // scoreboard: compare both instances against the model every cycle
  task automatic model_check();
    logic ev1, ev3;
    ev1 = 0; ev3 = 0;
    if (due1_q.size() > 0 && due1_q[0] == ecount) begin
      void'(due1_q.pop_front()); held1 = exp1_q.pop_front(); ev1 = 1;
    end
    if (due3_q.size() > 0 && due3_q[0] == ecount) begin
      void'(due3_q.pop_front()); held3 = exp3_q.pop_front(); ev3 = 1;
    end
    chk("model_valid_l1", {31'd0, rd_valid1}, {31'd0, ev1});
    chk("model_data_l1", rd_data1, held1);
    chk("model_valid_l3", {31'd0, rd_valid3}, {31'd0, ev3});
    chk("model_data_l3", rd_data3, held3);
    chk("model_debug", {24'd0, dbg1}, {24'd0, m_dbg});
    chk("model_err", {31'd0, err1}, {31'd0, m_err});
    chk("model_err_l3", {31'd0, err3}, {31'd0, m_err});
  endtask

  // driver tasks
  task automatic cycle(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d);
    rd_en = rd; wr_en = wr; o_addr = a; wr_data = d;
    @(posedge clk);
    model_edge(rd, wr, a, d);
    @(negedge clk);
    rd_en = 0; wr_en = 0;
    model_check();
  endtask

  task automatic do_reset();
    rd_en = 0; wr_en = 0; o_addr = 0; wr_data = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid_l1", {31'd0, rd_valid1}, 32'd0);
    chk("rst_valid_l3", {31'd0, rd_valid3}, 32'd0);
    chk("rst_data_l1", rd_data1, 32'd0);
    chk("rst_data_l3", rd_data3, 32'd0);
    chk("rst_debug", {24'd0, dbg1}, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        ev;
    logic [31:0] ed;
    logic [7:0]  edbg;
    logic        eerr;
  } vec_t;

  vec_t vecs[15];

  logic [31:0] c0, c1;

  initial begin
    // expected outputs are for the latency-1 instance, observed after the edge
    vecs[0]  = '{0, 1, 16'h0100, 32'h12345678, 0, 32'h00000000, 8'h00, 0};
    vecs[1]  = '{1, 0, 16'h0100, 32'h0,        1, 32'h12345678, 8'h00, 0};
    vecs[2]  = '{0, 0, 16'h0000, 32'h0,        0, 32'h12345678, 8'h00, 0};
    vecs[3]  = '{0, 1, 16'h0000, 32'hFFFFFFFF, 0, 32'h12345678, 8'h00, 0};
    vecs[4]  = '{1, 0, 16'h0000, 32'h0,        1, 32'h00000000, 8'h00, 0};
    vecs[5]  = '{1, 0, 16'h0002, 32'h0,        1, 32'h00000000, 8'h00, 0};
    vecs[6]  = '{0, 1, 16'hFFFC, 32'h123456A5, 0, 32'h00000000, 8'hA5, 0};
    vecs[7]  = '{1, 0, 16'hFFFC, 32'h0,        1, 32'h000000A5, 8'hA5, 0};
    vecs[8]  = '{0, 1, 16'hFFF8, 32'h00000055, 0, 32'h000000A5, 8'hA5, 0};
    vecs[9]  = '{1, 0, 16'h0103, 32'h0,        1, 32'h12345678, 8'hA5, 0};
    vecs[10] = '{0, 1, 16'h0200, 32'hDEAD0001, 0, 32'h12345678, 8'hA5, 0};
    vecs[11] = '{1, 0, 16'h0200, 32'h0,        1, 32'hDEAD0001, 8'hA5, 0};
    vecs[12] = '{1, 0, 16'h1000, 32'h0,        1, 32'hDEADBEEF, 8'hA5, 1};
    vecs[13] = '{1, 1, 16'h0204, 32'h00000077, 0, 32'hDEADBEEF, 8'hA5, 1};
    vecs[14] = '{1, 0, 16'h0204, 32'h0,        1, 32'h00000077, 8'hA5, 1};

    rst_n = 1'b1;
    rd_en = 0; wr_en = 0; o_addr = 0; wr_data = 0;
    ecount = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_valid", i), {31'd0, rd_valid1}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_data", i), rd_data1, vecs[i].ed);
      chk($sformatf("vec%0d_debug", i), {24'd0, dbg1}, {24'd0, vecs[i].edbg});
      chk($sformatf("vec%0d_err", i), {31'd0, err1}, {31'd0, vecs[i].eerr});
    end

    // latency-3 back-to-back reads return in order on consecutive cycles
    cycle(0, 1, 16'h0080, 32'd1);
    cycle(0, 1, 16'h0084, 32'd2);
    cycle(0, 1, 16'h0088, 32'd3);
    cycle(1, 0, 16'h0080, 32'd0);
    chk("l3_not_yet", {31'd0, rd_valid3}, 32'd0);
    cycle(1, 0, 16'h0084, 32'd0);
    chk("l3_not_yet2", {31'd0, rd_valid3}, 32'd0);
    cycle(1, 0, 16'h0088, 32'd0);
    chk("l3_first_valid", {31'd0, rd_valid3}, 32'd1);
    chk("l3_first_data", rd_data3, 32'd1);
    cycle(0, 0, 16'h0000, 32'd0);
    chk("l3_second_data", rd_data3, 32'd2);
    cycle(0, 0, 16'h0000, 32'd0);
    chk("l3_third_valid", {31'd0, rd_valid3}, 32'd1);
    chk("l3_third_data", rd_data3, 32'd3);
    cycle(0, 0, 16'h0000, 32'd0);
    chk("l3_after_valid", {31'd0, rd_valid3}, 32'd0);
    chk("l3_after_hold", rd_data3, 32'd3);

    // debug register and cycle counter spacing
    cycle(0, 1, 16'hFFFC, 32'h000000A5);
    chk("debug_a5", {24'd0, dbg1}, 32'h000000A5);
    cycle(1, 0, 16'hFFF8, 32'd0);
    c0 = rd_data1;
    repeat (4) cycle(0, 0, 16'h0000, 32'd0);
    cycle(1, 0, 16'hFFF8, 32'd0);
    c1 = rd_data1;
    chk("cycles_delta", c1 - c0, 32'd5);

    // reset while a latency-3 read is in flight
    cycle(1, 0, 16'h0100, 32'd0);
    do_reset();
    cycle(1, 0, 16'hFFF8, 32'd0);
    chk("cycles_restart", rd_data1, 32'd0);
    chk("no_stale_valid", {31'd0, rd_valid3}, 32'd0);
    repeat (3) cycle(0, 0, 16'h0000, 32'd0);
    cycle(1, 0, 16'h0100, 32'd0);
    chk("ram_retained", rd_data1, 32'h12345678);
    chk("debug_cleared", {24'd0, dbg1}, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 16; i++) cycle(0, 1, 16'(16'h0100 + 4 * i), $urandom);
    for (int n = 0; n < 400; n++) begin
      int sel, op;
      logic [15:0] a;
      sel = $urandom_range(0, 9);
      op  = $urandom_range(0, 9);
      if (sel <= 5) a = 16'(16'h0100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3));
      else if (sel == 6) a = 16'($urandom_range(0, 3));
      else if (sel == 7) a = 16'hFFF8;
      else if (sel == 8) a = 16'hFFFC;
      else a = 16'(16'h1000 + 4 * $urandom_range(0, 16'h0EFF));
      if (n == 200) do_reset();
      cycle(op <= 3 || op == 7, op >= 4 && op <= 7, a, $urandom);
    end
    repeat (4) cycle(0, 0, 16'h0000, 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
